// File: rtl/adder_pkg.sv
// Shared widths and segment arithmetic for the segmented pipelined adder.
package adder_pkg;
  localparam int DEF_A_WIDTH   = 45;
  localparam int DEF_B_WIDTH   = 2;
  localparam int DEF_SEG_WIDTH = 16;

  function automatic int seg_count(input int a_w, input int s_w);
    if (s_w < 1) return 1;
    return (a_w + s_w - 1) / s_w;
  endfunction

  function automatic int last_seg_width(input int a_w, input int s_w);
    return a_w - (seg_count(a_w, s_w) - 1) * s_w;
  endfunction
endpackage

// File: rtl/seg_adder_stage.sv
// One carry segment: adds its slice of A/B plus incoming carry, registers
// the partial result with the remaining operands and a valid bit.
module seg_adder_stage #(
  parameter int A_WIDTH   = 45,
  parameter int SEG_WIDTH = 16,
  parameter int IDX       = 0,
  parameter int SEG_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [A_WIDTH-1:0] up_a,
  input  logic [A_WIDTH-1:0] up_b,
  input  logic [A_WIDTH-1:0] up_sum,
  input  logic               up_carry,
  output logic               dn_valid,
  input  logic               dn_ready,
  output logic [A_WIDTH-1:0] dn_a,
  output logic [A_WIDTH-1:0] dn_b,
  output logic [A_WIDTH-1:0] dn_sum,
  output logic               dn_carry
);
  localparam int LO = IDX * SEG_WIDTH;

  logic [SEG_W:0]     seg_sum;
  logic [A_WIDTH-1:0] sum_next;
  logic               load;

  assign seg_sum = {1'b0, up_a[LO +: SEG_W]} + {1'b0, up_b[LO +: SEG_W]}
                 + {{SEG_W{1'b0}}, up_carry};

  always_comb begin
    sum_next = up_sum;
    sum_next[LO +: SEG_W] = seg_sum[SEG_W-1:0];
  end

  // Empty stages always accept, so bubbles collapse toward the output.
  assign up_ready = !dn_valid || dn_ready;
  assign load     = up_valid && up_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_a     <= '0;
      dn_b     <= '0;
      dn_sum   <= '0;
      dn_carry <= 1'b0;
    end else begin
      if (up_ready) dn_valid <= up_valid;
      // Data only moves with a real transaction so the output holds when idle.
      if (load) begin
        dn_a     <= up_a;
        dn_b     <= up_b;
        dn_sum   <= sum_next;
        dn_carry <= seg_sum[SEG_W];
      end
    end
  end
endmodule

// File: rtl/seg_pipelined_adder.sv
// Pipelined A + zext(B) + cin, carry chain cut into SEG_WIDTH-bit stages
// with valid/ready flow control on both sides.
module seg_pipelined_adder
  import adder_pkg::*;
#(
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int B_WIDTH   = DEF_B_WIDTH,
  parameter int SEG_WIDTH = DEF_SEG_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] in_a,
  input  logic [B_WIDTH-1:0] in_b,
  input  logic               in_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_WIDTH:0]   out_sum
);
  localparam int NUM_SEG = seg_count(A_WIDTH, SEG_WIDTH);
  localparam int LAST_W  = last_seg_width(A_WIDTH, SEG_WIDTH);

  if ((A_WIDTH < 2) || (B_WIDTH < 1) || (B_WIDTH > A_WIDTH) ||
      (SEG_WIDTH < 1) || (SEG_WIDTH > A_WIDTH)) begin : g_bad_params
    $error("seg_pipelined_adder: illegal A_WIDTH/B_WIDTH/SEG_WIDTH");
  end

  logic [NUM_SEG:0]   vld_pipe;
  logic [NUM_SEG:0]   rdy_pipe;
  logic [NUM_SEG:0]   cry_pipe;
  logic [A_WIDTH-1:0] a_pipe [NUM_SEG+1];
  logic [A_WIDTH-1:0] b_pipe [NUM_SEG+1];
  logic [A_WIDTH-1:0] s_pipe [NUM_SEG+1];

  assign vld_pipe[0]       = in_valid;
  assign cry_pipe[0]       = in_cin;
  assign a_pipe[0]         = in_a;
  assign b_pipe[0]         = A_WIDTH'(in_b);
  assign s_pipe[0]         = '0;
  assign rdy_pipe[NUM_SEG] = out_ready;

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
    seg_adder_stage #(
      .A_WIDTH  (A_WIDTH),
      .SEG_WIDTH(SEG_WIDTH),
      .IDX      (k),
      .SEG_W    ((k == NUM_SEG - 1) ? LAST_W : SEG_WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .up_valid(vld_pipe[k]),
      .up_ready(rdy_pipe[k]),
      .up_a    (a_pipe[k]),
      .up_b    (b_pipe[k]),
      .up_sum  (s_pipe[k]),
      .up_carry(cry_pipe[k]),
      .dn_valid(vld_pipe[k+1]),
      .dn_ready(rdy_pipe[k+1]),
      .dn_a    (a_pipe[k+1]),
      .dn_b    (b_pipe[k+1]),
      .dn_sum  (s_pipe[k+1]),
      .dn_carry(cry_pipe[k+1])
    );
  end

  // Masked so nothing is offered as accepted while reset is held.
  assign in_ready  = !rst && rdy_pipe[0];
  assign out_valid = vld_pipe[NUM_SEG];
  assign out_sum   = {cry_pipe[NUM_SEG], s_pipe[NUM_SEG]};
endmodule

// File: tb/tb_seg_pipelined_adder.sv
// Self-checking bench: directed table, random streaming, back-pressure,
// mid-stream reset and a parameter sweep against a plain-arithmetic model.
module tb_seg_pipelined_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_cin = 1'b0, out_ready = 1'b1;
  logic [44:0] in_a = '0;
  logic [1:0]  in_b = '0;
  logic        in_ready, out_valid;
  logic [45:0] out_sum;

  logic [2:0]  sw_vld = '0;
  logic [2:0]  sw_rdy, sw_ov;
  logic [63:0] sw_a = '1;
  logic [7:0]  sw_b = '1;
  logic        sw_cin = 1'b1;
  logic [8:0]  s0_sum;
  logic [45:0] s1_sum;
  logic [64:0] s2_sum;

  int errors = 0, checks = 0;
  int n_acc = 0, n_rcv = 0;
  logic [45:0] q[$];

  always #5 clk = ~clk;

  seg_pipelined_adder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum));

  seg_pipelined_adder #(.A_WIDTH(8), .B_WIDTH(8), .SEG_WIDTH(8)) u_s0 (
    .clk(clk), .rst(rst), .in_valid(sw_vld[0]), .in_ready(sw_rdy[0]),
    .in_a(sw_a[7:0]), .in_b(sw_b[7:0]), .in_cin(sw_cin), .out_valid(sw_ov[0]),
    .out_ready(1'b1), .out_sum(s0_sum));

  seg_pipelined_adder #(.A_WIDTH(45), .B_WIDTH(2), .SEG_WIDTH(7)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(sw_vld[1]), .in_ready(sw_rdy[1]),
    .in_a(sw_a[44:0]), .in_b(sw_b[1:0]), .in_cin(sw_cin), .out_valid(sw_ov[1]),
    .out_ready(1'b1), .out_sum(s1_sum));

  seg_pipelined_adder #(.A_WIDTH(64), .B_WIDTH(4), .SEG_WIDTH(1)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(sw_vld[2]), .in_ready(sw_rdy[2]),
    .in_a(sw_a[63:0]), .in_b(sw_b[3:0]), .in_cin(sw_cin), .out_valid(sw_ov[2]),
    .out_ready(1'b1), .out_sum(s2_sum));

  typedef struct {
    logic [44:0] a;
    logic [1:0]  b;
    logic        cin;
    logic [45:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [45:0] ref_sum(input logic [44:0] a, input logic [1:0] b, input logic c);
    return 46'(a) + 46'(b) + 46'(c);
  endfunction

  task automatic rand_inputs();
    in_a   = 45'({$urandom(), $urandom()});
    in_b   = 2'($urandom());
    in_cin = 1'($urandom());
  endtask

  // Called after inputs are set following a negedge; scores this cycle's transfers.
  task automatic step();
    logic [45:0] e;
    #1;
    if (in_valid && in_ready) begin
      q.push_back(ref_sum(in_a, in_b, in_cin));
      n_acc++;
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_output", 65'(out_sum), 65'(0));
      else begin
        e = q.pop_front();
        chk("scoreboard_sum", 65'(out_sum), 65'(e));
        n_rcv++;
      end
    end
  endtask

  task automatic single(input string name, input logic [44:0] a, input logic [1:0] b,
                        input logic c, input logic [45:0] exp);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = c; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 65'(n), 65'(3));
    chk({name, "_sum"}, 65'(out_sum), 65'(exp));
  endtask

  task automatic sweep(input int i, input int aw, input int bw, input int lat);
    int n;
    logic [64:0] got, exp;
    exp = ((65'(1) << aw) - 65'(1)) + ((65'(1) << bw) - 65'(1)) + 65'(1);
    @(negedge clk);
    sw_vld[i] = 1'b1;
    @(negedge clk);
    sw_vld[i] = 1'b0;
    n = 1;
    while (!sw_ov[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    got = (i == 0) ? 65'(s0_sum) : (i == 1) ? 65'(s1_sum) : s2_sum;
    chk($sformatf("sweep%0d_latency", i), 65'(n), 65'(lat));
    chk($sformatf("sweep%0d_sum", i), got, exp);
  endtask

  initial begin
    vec_t tbl[4];
    int last_cyc, acc;
    logic [45:0] held;
    logic have;

    tbl[0] = '{45'h1FFF_FFFF_FFFF, 2'b01, 1'b0, 46'h2000_0000_0000};
    tbl[1] = '{45'h0,              2'b00, 1'b1, 46'h1};
    tbl[2] = '{45'h0000_0000_FFFF, 2'b11, 1'b1, 46'h0000_0001_0003};
    tbl[3] = '{45'h1FFF_FFFF_FFFF, 2'b11, 1'b1, 46'h2000_0000_0003};

    repeat (2) @(negedge clk);
    chk("reset_out_valid", 65'(out_valid), 65'(0));
    chk("reset_in_ready", 65'(in_ready), 65'(0));
    chk("reset_out_sum", 65'(out_sum), 65'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", 65'(in_ready), 65'(1));

    for (int i = 0; i < 4; i++) single($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].exp);
    chk("idle_hold_sum", 65'(out_sum), 65'(tbl[3].exp));

    // Streaming: 100 back-to-back, one result per cycle after fill.
    n_acc = 0; n_rcv = 0; last_cyc = -1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && n_rcv < 100; cyc++) begin
      @(negedge clk);
      in_valid = (n_acc < 100);
      if (in_valid) rand_inputs();
      acc = n_rcv;
      step();
      if (n_rcv != acc) last_cyc = cyc;
    end
    in_valid = 1'b0;
    chk("stream_count", 65'(n_rcv), 65'(100));
    chk("stream_last_cycle", 65'(last_cyc), 65'(102));

    // Back-pressure: fill with out_ready low, hold output stable.
    @(negedge clk);
    out_ready = 1'b0; acc = 0; have = 1'b0; held = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      rand_inputs();
      #1;
      if (in_valid && in_ready) begin
        q.push_back(ref_sum(in_a, in_b, in_cin));
        acc++;
      end
      if (out_valid) begin
        if (!have) begin held = out_sum; have = 1'b1; end
        else chk("bp_hold", 65'(out_sum), 65'(held));
      end
    end
    chk("bp_accepted", 65'(acc), 65'(3));
    chk("bp_in_ready_full", 65'(in_ready), 65'(0));
    chk("bp_out_valid", 65'(out_valid), 65'(1));
    chk("bp_head", 65'(held), (q.size() > 0) ? 65'(q[0]) : 65'h1_FFFF_FFFF_FFFF_FFFF);

    // Accept and consume together on a full pipeline.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; rand_inputs();
    step();
    chk("full_swap_in_ready", 65'(in_ready), 65'(1));
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("full_after_swap_valid", 65'(out_valid), 65'(1));
    chk("full_after_swap_ready", 65'(in_ready), 65'(0));
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      step();
    end
    chk("drain_empty", 65'(q.size()), 65'(0));
    @(negedge clk);
    #1;
    chk("drain_idle", 65'(out_valid), 65'(0));

    // Reset asynchronously with three in flight.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1; rand_inputs();
      step();
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 65'(out_valid), 65'(0));
    chk("midrst_in_ready", 65'(in_ready), 65'(0));
    chk("midrst_out_sum", 65'(out_sum), 65'(0));
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("no_stale", 65'(out_valid), 65'(0));
    end
    single("after_reset", 45'h1234_5678_9ABC, 2'b10, 1'b1, ref_sum(45'h1234_5678_9ABC, 2'b10, 1'b1));

    sweep(0, 8, 8, 1);
    sweep(1, 45, 2, 7);
    sweep(2, 64, 4, 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_pipelined_adder.md
Name: seg_pipelined_adder

Overview:
- Parametrised, pipelined successor to the fixed 45+2-bit custom adder used in the multiplier datapath.
- Adds a wide unsigned operand A to a narrower, zero-extended unsigned operand B, plus a carry-in, and produces a full-width sum with carry-out.
- The carry chain is cut into SEG_WIDTH-bit segments, one register stage per segment, so wide additions close timing.
- Sits between partial-product accumulation and result packing, with valid/ready handshakes on both sides.

Parameters:
- A_WIDTH, 45, width of operand A and of the sum body; must be >= 2.
- B_WIDTH, 2, width of operand B; 1 <= B_WIDTH <= A_WIDTH; zero-extended to A_WIDTH.
- SEG_WIDTH, 16, carry-segment width per pipeline stage; 1 <= SEG_WIDTH <= A_WIDTH.
- Derived NUM_SEG = ceil(A_WIDTH/SEG_WIDTH); default is 3.
- Derived LAST_W = A_WIDTH-(NUM_SEG-1)*SEG_WIDTH; default is 13.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block accepts an input this cycle.
- in_a  in  A_WIDTH  operand A, unsigned.
- in_b  in  B_WIDTH  operand B, unsigned.
- in_cin  in  1  carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  A_WIDTH+1  A + zext(B) + cin; MSB is the carry-out.

Behaviour:
- Reset: asynchronous and active-high. While rst=1, all stage valid bits, out_valid and out_sum are 0, and in_ready=0. On the first edge after deassertion, in_ready=1 because the pipeline is empty.
- Reset mid-operation: every in-flight transaction is discarded and none appears at the output afterwards.
- Transfer rules: an input is accepted when in_valid & in_ready at a rising edge. A result is consumed when out_valid & out_ready.
- Stage k (k = 0..NUM_SEG-1) adds segment k of A, segment k of zext(B), and the carry from stage k-1 (in_cin for stage 0). It registers:
  - sum bits [k*SEG_WIDTH +: seg_w], with seg_w = SEG_WIDTH, or LAST_W for the final stage;
  - the carry-out;
  - the lower sum bits already computed;
  - the not-yet-added upper A and B segments;
  - a valid bit.
- Latency: exactly NUM_SEG cycles from acceptance to out_valid, with no stalls. Default is 3.
- Throughput: one result per cycle while out_ready=1.
- Back-pressure is per stage:
  - stage k loads when stage k is empty, or when its content moves to k+1 (or is consumed, for the last stage) in the same cycle;
  - in_ready = !valid0 | advance0, combinational from out_ready through the chain.
- Bubbles collapse: a non-empty stage advances into an empty downstream stage even when out_ready=0.
- Output hold: while out_valid=1 and out_ready=0, out_sum and out_valid hold stable. No result is dropped or duplicated.
- out_sum is registered. It holds its last value when out_valid=0, and is 0 after reset.
- Full pipeline (all stages valid, out_ready=0): in_ready=0.
- Simultaneous accept and consume on a full pipeline: both happen and occupancy is unchanged.
- Arithmetic is modulo-free: out_sum[A_WIDTH] is the true carry-out. The maximum value is (2^A_WIDTH-1)+(2^B_WIDTH-1)+1.
- When NUM_SEG=1 the block degenerates to a single registered adder with latency 1.
- Illegal parameter combinations stop elaboration with an error.

Decomposition:
- Shared package (adder_pkg):
  - constant functions seg_count(a_w, s_w) and last_seg_width(a_w, s_w);
  - the default widths 45/2/16 used by the multiplier datapath.
- Sub-module seg_adder_stage: one segment full-adder plus its pipeline register and valid/ready logic, parametrised by segment width and position. seg_pipelined_adder instantiates NUM_SEG of them via generate.

Test Plan:
1. Reset and single add (defaults): in_a=45'h1FFF_FFFF_FFFF, in_b=2'b01, cin=0 -> after 3 cycles out_valid=1, out_sum=46'h2000_0000_0000 (carry ripples through all segments).
2. Carry-in only: in_a=0, in_b=0, cin=1 -> out_sum=1. Then in_a=45'h0000_0000_FFFF, in_b=2'b11, cin=1 -> out_sum=46'h0000_0001_0003.
3. Streaming with out_ready=1: 100 back-to-back random transactions -> 100 results, in order, each matching the reference sum, one per cycle after a 3-cycle fill.
4. Back-pressure: out_ready=0 for 10 cycles while feeding -> exactly 3 accepted, in_ready=0 thereafter, out_sum stable. Releasing out_ready drains all 3 in order with no loss or duplication.
5. Reset mid-stream: assert rst asynchronously (between edges) with 3 transactions in flight -> out_valid=0 immediately, in_ready=0. After release, no stale result appears and the next accepted add has latency 3.
6. Parameter sweep: (A_WIDTH, B_WIDTH, SEG_WIDTH) = (8,8,8), (45,2,7), (64,4,1) -> latency equals NUM_SEG (1, 7, 64) and all-ones A plus max B plus cin=1 gives the correct carry-out.
